name_hash_table: RTL and testbench

Hash-indexed name table for the router's PIT/FIB path. It consumes the 10-bit index that the name hash stage produces alongside the 64-bit name, and stores, finds or removes {name, face} entries. Collisions are resolved by bounded linear probing. It is a single-outstanding request/response engine with valid/ready handshakes on both sides, and it sits directly downstream of the hash stage.

---
 rtl/name_hash_table_if.sv | 38 +++
 rtl/name_hash_table.sv | 191 +++++++++++++++++++
 tb/tb_name_hash_table.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/name_hash_table_if.sv
// Request/response bundle between the hash stage, the name table and its consumer.
// master: drives the request and rsp_ready (hash stage / consumer side).
// slave : the name_hash_table engine.
// Signals:
//   req_valid/req_ready  request handshake
//   req_op               00 lookup, 01 insert, 10 delete, 11 lookup
//   req_key/req_hash     name key and its home index
//   req_val              face id to store on insert
//   rsp_valid/rsp_ready  response handshake
//   rsp_hit/rsp_val      found flag and stored face id (lookup hit)
//   rsp_full             insert found neither a match nor a free slot
interface name_hash_table_if #(
  parameter int KEY_W = 64,
  parameter int IDX_W = 10,
  parameter int VAL_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [KEY_W-1:0] req_key;
  logic [IDX_W-1:0] req_hash;
  logic [VAL_W-1:0] req_val;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic [VAL_W-1:0] rsp_val;
  logic             rsp_full;

  modport master (
    output req_valid, req_op, req_key, req_hash, req_val, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_val, rsp_full
  );

  modport slave (
    input  req_valid, req_op, req_key, req_hash, req_val, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_val, rsp_full
  );
endinterface

// File: rtl/name_hash_table.sv
// Hash-indexed {name, face} table with bounded linear probing.
// Single outstanding request: accept in IDLE, probe MAX_PROBE slots starting
// at the home index (wrapping), optionally write once, then hold the response
// until the consumer takes it. After reset the valid bits are cleared one
// entry per cycle before the first request is accepted.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  name_hash_table_if slave modport (request and response handshakes)
module name_hash_table #(
  parameter int KEY_W     = 64,
  parameter int IDX_W     = 10,
  parameter int VAL_W     = 8,
  parameter int MAX_PROBE = 4
) (
  input  logic               clk,
  input  logic               rst,
  name_hash_table_if.slave   bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] P_LAST = 4'(MAX_PROBE - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_WR, S_RSP} state_t;

  state_t r_state, w_state_nxt;

  logic             r_mem_vld [DEPTH];
  logic [KEY_W-1:0] r_mem_key [DEPTH];
  logic [VAL_W-1:0] r_mem_val [DEPTH];

  logic [IDX_W-1:0] r_init_idx;
  logic [1:0]       r_op;
  logic [KEY_W-1:0] r_key;
  logic [IDX_W-1:0] r_hash;
  logic [VAL_W-1:0] r_val;
  logic [3:0]       r_probe;
  logic [IDX_W-1:0] r_cur_addr;
  logic             r_free_vld;
  logic [IDX_W-1:0] r_free_idx;
  logic             r_rd_vld;
  logic [KEY_W-1:0] r_rd_key;
  logic [VAL_W-1:0] r_rd_val;
  logic [IDX_W-1:0] r_wr_addr;
  logic             r_wr_vld;
  logic [VAL_W-1:0] r_wr_val;
  logic             r_rsp_hit;
  logic [VAL_W-1:0] r_rsp_val;
  logic             r_rsp_full;

  logic             w_match, w_is_ins, w_is_del;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_rd_addr;
  logic             w_set_rsp, w_hit, w_full, w_wr_set, w_wr_vld, w_probe_inc;
  logic [VAL_W-1:0] w_rval, w_wr_val;
  logic [IDX_W-1:0] w_wr_addr;
  logic             w_we;
  logic [IDX_W-1:0] w_we_addr;

  assign w_rd_addr  = r_hash + IDX_W'(r_probe);
  assign w_match    = r_rd_vld && (r_rd_key == r_key);
  assign w_is_ins   = (r_op == 2'b01);
  assign w_is_del   = (r_op == 2'b10);
  // The slot just read counts as a free candidate on the last probe as well.
  assign w_free_any = r_free_vld || !r_rd_vld;
  assign w_free_idx = r_free_vld ? r_free_idx : r_cur_addr;

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.rsp_hit   = r_rsp_hit;
  assign bus.rsp_val   = r_rsp_val;
  assign bus.rsp_full  = r_rsp_full;

  always_comb begin
    w_state_nxt = r_state;
    w_set_rsp   = 1'b0;
    w_hit       = 1'b0;
    w_full      = 1'b0;
    w_rval      = '0;
    w_wr_set    = 1'b0;
    w_wr_addr   = r_cur_addr;
    w_wr_vld    = 1'b0;
    w_wr_val    = r_val;
    w_probe_inc = 1'b0;
    unique case (r_state)
      S_INIT: if (r_init_idx == '1) w_state_nxt = S_IDLE;
      S_IDLE: if (bus.req_valid) w_state_nxt = S_RD;
      S_RD:   w_state_nxt = S_CMP;
      S_CMP: begin
        if (w_match) begin
          w_set_rsp = 1'b1;
          w_hit     = 1'b1;
          if (w_is_ins) begin
            w_wr_set    = 1'b1;
            w_wr_vld    = 1'b1;
            w_state_nxt = S_WR;
          end else if (w_is_del) begin
            w_wr_set    = 1'b1;
            w_wr_val    = r_rd_val;
            w_state_nxt = S_WR;
          end else begin
            w_rval      = r_rd_val;
            w_state_nxt = S_RSP;
          end
        end else if (r_probe < P_LAST) begin
          w_probe_inc = 1'b1;
          w_state_nxt = S_RD;
        end else begin
          w_set_rsp = 1'b1;
          if (w_is_ins && w_free_any) begin
            w_wr_set    = 1'b1;
            w_wr_addr   = w_free_idx;
            w_wr_vld    = 1'b1;
            w_state_nxt = S_WR;
          end else begin
            w_full      = w_is_ins;
            w_state_nxt = S_RSP;
          end
        end
      end
      S_WR:   w_state_nxt = S_RSP;
      S_RSP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
      r_probe    <= '0;
      r_free_vld <= 1'b0;
      r_rsp_hit  <= 1'b0;
      r_rsp_val  <= '0;
      r_rsp_full <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_idx <= r_init_idx + 1'b1;
      if (r_state == S_IDLE && bus.req_valid) begin
        r_probe    <= '0;
        r_free_vld <= 1'b0;
      end
      if (r_state == S_CMP && !w_match && !r_rd_vld && !r_free_vld) r_free_vld <= 1'b1;
      if (w_probe_inc) r_probe <= r_probe + 4'd1;
      if (w_set_rsp) begin
        r_rsp_hit  <= w_hit;
        r_rsp_val  <= w_rval;
        r_rsp_full <= w_full;
      end else if (r_state == S_RSP && bus.rsp_ready) begin
        r_rsp_hit  <= 1'b0;
        r_rsp_val  <= '0;
        r_rsp_full <= 1'b0;
      end
    end
  end

  // Request capture and write staging (data only, no reset)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.req_valid) begin
      r_op   <= bus.req_op;
      r_key  <= bus.req_key;
      r_hash <= bus.req_hash;
      r_val  <= bus.req_val;
    end
    if (r_state == S_CMP && !w_match && !r_rd_vld && !r_free_vld) r_free_idx <= r_cur_addr;
    if (w_wr_set) begin
      r_wr_addr <= w_wr_addr;
      r_wr_vld  <= w_wr_vld;
      r_wr_val  <= w_wr_val;
    end
  end

  // Table storage: one write port shared by INIT clearing and WR, 1-cycle read
  assign w_we      = (r_state == S_INIT) || (r_state == S_WR);
  assign w_we_addr = (r_state == S_INIT) ? r_init_idx : r_wr_addr;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem_vld[w_we_addr] <= (r_state == S_WR) && r_wr_vld;
      r_mem_key[w_we_addr] <= r_key;
      r_mem_val[w_we_addr] <= r_wr_val;
    end
    if (r_state == S_RD) begin
      r_cur_addr <= w_rd_addr;
      r_rd_vld   <= r_mem_vld[w_rd_addr];
      r_rd_key   <= r_mem_key[w_rd_addr];
      r_rd_val   <= r_mem_val[w_rd_addr];
    end
  end
endmodule

// File: tb/tb_name_hash_table.sv
module tb_name_hash_table;
  localparam int KEY_W = 64;
  localparam int IDX_W = 10;
  localparam int VAL_W = 8;
  localparam int MAX_PROBE = 4;

  localparam logic [1:0] OP_LK = 2'b00;
  localparam logic [1:0] OP_IN = 2'b01;
  localparam logic [1:0] OP_DL = 2'b10;
  localparam logic [1:0] OP_L3 = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  name_hash_table_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .VAL_W(VAL_W)) bus ();

  name_hash_table #(.KEY_W(KEY_W), .IDX_W(IDX_W), .VAL_W(VAL_W), .MAX_PROBE(MAX_PROBE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles from rst release until req_ready, watching rsp_* stay 0.
  task automatic init_window(input string tag);
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    while (!bus.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid || bus.rsp_hit || bus.rsp_full || (bus.rsp_val != '0)) bad = 1'b1;
    end
    chk({tag, "_init_cycles"}, 64'(n), 64'd1024);
    chk({tag, "_init_rsp_quiet"}, 64'(bad), 64'd0);
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [63:0] key,
                        input logic [9:0] hash, input logic [7:0] val, input int stall,
                        input int exp_edge, input logic exp_hit, input logic [7:0] exp_val,
                        input logic exp_full);
    int n;
    n = 0;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_hash  = hash;
    bus.req_val   = val;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields after the accept edge; they must be ignored.
    bus.req_valid = 1'b0;
    bus.req_key   = ~key;
    bus.req_hash  = ~hash;
    bus.req_val   = ~val;
    bus.req_op    = ~op;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_edge"}, 64'(n), 64'(exp_edge));
    chk({tag, "_hit"},  64'(bus.rsp_hit),  64'(exp_hit));
    chk({tag, "_val"},  64'(bus.rsp_val),  64'(exp_val));
    chk({tag, "_full"}, 64'(bus.rsp_full), 64'(exp_full));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, "_stall_hit"},   64'(bus.rsp_hit),   64'(exp_hit));
      chk({tag, "_stall_val"},   64'(bus.rsp_val),   64'(exp_val));
      chk({tag, "_stall_full"},  64'(bus.rsp_full),  64'(exp_full));
      chk({tag, "_stall_rdy"},   64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_post_clr"}, 64'({bus.rsp_hit, bus.rsp_full, bus.rsp_val}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ka, kb, kr, kx;
    int n;
    ka = 64'hA000_0000_0000_00AA;
    kb = 64'hB000_0000_0000_00BB;
    kr = 64'hC0FF_EE00_1234_5678;
    kx = 64'h0BAD_0BAD_0BAD_0BAD;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LK;
    bus.req_key   = '0;
    bus.req_hash  = '0;
    bus.req_val   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp", 64'({bus.rsp_valid, bus.rsp_hit, bus.rsp_full, bus.rsp_val}), 64'd0);

    // Hold req_valid through INIT; it must not be taken before req_ready rises.
    bus.req_valid = 1'b1;
    rst = 1'b0;
    init_window("por");
    bus.req_valid = 1'b0;

    do_req("ins_dead",  OP_IN, 64'hDEADBEEF_00000001, 10'h005, 8'h3C, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("lk_dead",   OP_LK, 64'hDEADBEEF_00000001, 10'h005, 8'h00, 0, 2, 1'b1, 8'h3C, 1'b0);
    do_req("lk3_dead",  OP_L3, 64'hDEADBEEF_00000001, 10'h005, 8'h00, 0, 2, 1'b1, 8'h3C, 1'b0);

    // Cluster at 0x3FE wraps through 0x3FF, 0x000, 0x001.
    do_req("ins_k1", OP_IN, 64'h1111_0000_0000_0001, 10'h3FE, 8'h41, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("ins_k2", OP_IN, 64'h1111_0000_0000_0002, 10'h3FE, 8'h42, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("ins_k3", OP_IN, 64'h1111_0000_0000_0003, 10'h3FE, 8'h43, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("ins_k4", OP_IN, 64'h1111_0000_0000_0004, 10'h3FE, 8'h44, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("ins_k5", OP_IN, 64'h1111_0000_0000_0005, 10'h3FE, 8'h45, 0, 8, 1'b0, 8'h00, 1'b1);
    do_req("lk_k4",  OP_LK, 64'h1111_0000_0000_0004, 10'h3FE, 8'h00, 0, 8, 1'b1, 8'h44, 1'b0);
    do_req("lk_k3",  OP_LK, 64'h1111_0000_0000_0003, 10'h3FE, 8'h00, 0, 6, 1'b1, 8'h43, 1'b0);
    // Probing from 0x3FF wraps to 0x000 where k3 lives: probe 1.
    do_req("lk_k3w", OP_LK, 64'h1111_0000_0000_0003, 10'h3FF, 8'h00, 0, 4, 1'b1, 8'h43, 1'b0);
    do_req("lk_k5",  OP_LK, 64'h1111_0000_0000_0005, 10'h3FE, 8'h00, 0, 8, 1'b0, 8'h00, 1'b0);

    // Delete leaves a hole; B is still found behind it and A refills the hole.
    do_req("ins_a",  OP_IN, ka, 10'h010, 8'hA0, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("ins_b",  OP_IN, kb, 10'h010, 8'hB0, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("del_a",  OP_DL, ka, 10'h010, 8'h00, 0, 3, 1'b1, 8'h00, 1'b0);
    do_req("del_a2", OP_DL, ka, 10'h010, 8'h00, 0, 8, 1'b0, 8'h00, 1'b0);
    do_req("lk_b",   OP_LK, kb, 10'h010, 8'h00, 0, 4, 1'b1, 8'hB0, 1'b0);
    do_req("rins_a", OP_IN, ka, 10'h010, 8'hA1, 0, 9, 1'b0, 8'h00, 1'b0);
    do_req("lk_a",   OP_LK, ka, 10'h010, 8'h00, 0, 2, 1'b1, 8'hA1, 1'b0);

    // Update of an existing key, then absent-key lookup.
    do_req("upd_a",  OP_IN, ka, 10'h010, 8'h77, 0, 3, 1'b1, 8'h00, 1'b0);
    do_req("lk_a77", OP_LK, ka, 10'h010, 8'h00, 0, 2, 1'b1, 8'h77, 1'b0);
    do_req("lk_abs", OP_LK, kx, 10'h200, 8'h00, 0, 8, 1'b0, 8'h00, 1'b0);

    // Consumer back-pressure for 20 cycles.
    do_req("stall",  OP_LK, kb, 10'h010, 8'h00, 20, 4, 1'b1, 8'hB0, 1'b0);

    // Reset while an insert sits in RD.
    n = 0;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bus.req_op    = OP_IN;
    bus.req_key   = kr;
    bus.req_hash  = 10'h100;
    bus.req_val   = 8'h5A;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", 64'(bus.req_ready), 64'd0);
    chk("midrst_rsp", 64'({bus.rsp_valid, bus.rsp_hit, bus.rsp_full, bus.rsp_val}), 64'd0);
    rst = 1'b0;
    init_window("midrst");
    do_req("lk_kr",      OP_LK, kr, 10'h100, 8'h00, 0, 8, 1'b0, 8'h00, 1'b0);
    do_req("lk_dead_cl", OP_LK, 64'hDEADBEEF_00000001, 10'h005, 8'h00, 0, 8, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
